mult_div_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage of the five-stage pipeline.
- Operands come straight from the EX-stage operand selection muxes (forwarded register, writeback value, or shift-amount path).
- Executes MULT/MULTU/DIV/DIVU over DATA_WIDTH+2 cycles and writes the HI/LO result registers.
- Raises stall_o so hazard control freezes IF/ID/EX while an operation is in flight.

---
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. One shift-add or restoring
// step per cycle, followed by a sign-correction cycle that writes HI/LO.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] src1_i,
  input  logic [DATA_WIDTH-1:0] src2_i,
  input  logic [1:0]            op_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  stall_o
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2*W-1:0]       r_acc;
  logic [W-1:0]         r_opnd;
  logic [W-1:0]         r_hi, r_lo;
  logic                 r_is_div, r_neg_res, r_neg_a, r_div0;

  logic                 w_idle_or_done, w_accept, w_signed, w_neg_a, w_neg_b;
  logic [W-1:0]         w_mag_a, w_mag_b;
  logic [W:0]           w_mul_sum, w_rem_sh;
  logic [W-1:0]         w_rem_sub;
  logic                 w_ge;
  logic [2*W-1:0]       w_mul_step, w_div_step;
  logic [W-1:0]         w_res_hi, w_res_lo;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept       = w_idle_or_done && start_i;
  assign w_signed       = ~op_i[0];
  assign w_neg_a        = w_signed & src1_i[W-1];
  assign w_neg_b        = w_signed & src2_i[W-1];
  assign w_mag_a        = cond_neg(src1_i, w_neg_a);
  assign w_mag_b        = cond_neg(src2_i, w_neg_b);

  // Multiply: {partial product, remaining multiplier bits} shifts right each step
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[W-1:1]};

  // Divide: {remainder, remaining dividend bits / growing quotient} shifts left
  assign w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_opnd};
  assign w_rem_sub  = w_rem_sh[W-1:0] - r_opnd;
  assign w_div_step = {(w_ge ? w_rem_sub : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    if (r_is_div) begin
      // A zero divisor leaves the quotient all ones regardless of sign
      w_res_lo = cond_neg(r_acc[W-1:0], r_neg_res & ~r_div0);
      w_res_hi = cond_neg(r_acc[2*W-1:W], r_neg_a);
    end else begin
      {w_res_hi, w_res_lo} = r_neg_res ? -r_acc : r_acc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: w_next = start_i ? S_CALC : S_IDLE;
        S_CALC:         w_next = (r_cnt == CNT_WIDTH'(W-1)) ? S_SIGN : S_CALC;
        S_SIGN:         w_next = S_DONE;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (r_state == S_CALC) || (r_state == S_SIGN);
    done_o  = (r_state == S_DONE);
    stall_o = busy_o || w_accept;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_div0    <= 1'b0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_cnt     <= '0;
            r_is_div  <= op_i[1];
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_a   <= w_neg_a;
            r_div0    <= (src2_i == '0);
            r_opnd    <= op_i[1] ? w_mag_b : w_mag_a;
            r_acc     <= {{W{1'b0}}, (op_i[1] ? w_mag_a : w_mag_b)};
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          r_acc <= r_is_div ? w_div_step : w_mul_step;
        end
        S_SIGN: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes model results, a monitor
// pops and compares on every done_o pulse.
module tb_mult_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [W-1:0]  src1_i = '0, src2_i = '0;
  logic [1:0]    op_i = '0;
  logic          start_i = 1'b0, flush_i = 1'b0;
  logic [W-1:0]  hi_o, lo_o;
  logic          busy_o, done_o, stall_o;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [63:0]   exp_q[$];
  logic [W-1:0]  cur_hi = '0, cur_lo = '0;

  mult_div_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .src1_i(src1_i), .src2_i(src2_i), .op_i(op_i),
    .start_i(start_i), .flush_i(flush_i), .hi_o(hi_o), .lo_o(lo_o),
    .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("result_hi_lo", {hi_o, lo_o}, exp_q.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int restart_at);
    logic [63:0] r;
    int          cyc;
    bit          ok;
    r = model(op, a, b);
    ok = 1'b1;
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    #1 check("stall_on_start", 64'(stall_o), 64'd1);
    exp_q.push_back(r);
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 60) begin
      if (!busy_o || !stall_o || hi_o !== cur_hi || lo_o !== cur_lo) ok = 1'b0;
      if (cyc == restart_at) begin
        start_i = 1'b1; op_i = 2'($urandom); src1_i = $urandom; src2_i = $urandom;
      end
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
    end
    check("latency", 64'(cyc), 64'd34);
    check("busy_and_hold_during_calc", 64'(ok), 64'd1);
    cur_hi = r[63:32];
    cur_lo = r[31:0];
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    #12;
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    @(negedge clk);
    run_op(2'd3, 32'd100, 32'd0, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0);
    run_op(2'd3, 32'h0ACF_1234, 32'h2000, 0);

    // Flush a running MULTU at cycle 10; prior result must survive
    @(negedge clk);
    op_i = 2'd1; src1_i = 32'd5; src2_i = 32'd6; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_hold", {hi_o, lo_o}, {32'h1234, 32'h5678});
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("no_done_after_flush", 64'(seen), 64'd0);
    run_op(2'd1, 32'd5, 32'd6, 0);

    @(negedge clk);
    run_op(2'd3, 32'd1000, 32'd7, 5);

    // Asynchronous reset in the middle of a MULT
    @(negedge clk);
    op_i = 2'd0; src1_i = 32'hFFFF_FFFD; src2_i = 32'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (16) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_hi_lo", {hi_o, lo_o}, 64'd0);
    check("async_rst_busy", 64'(busy_o), 64'd0);
    check("async_rst_done", 64'(done_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("no_done_after_reset", 64'(seen), 64'd0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op(2'($urandom), pick(), pick(), 0);
    end

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
